// File: rtl/card_pkg.sv
// Shared card definitions: field widths, deck size and the deck FSM encoding.
// Also used by card_value, so every card consumer agrees on the card layout.
package card_pkg;

    localparam int unsigned CARD_COL_W     = 2;
    localparam int unsigned CARD_NUM_W     = 3;
    localparam int unsigned CARD_IDX_W     = CARD_COL_W + CARD_NUM_W;
    localparam int unsigned CARD_DECK_SIZE = 1 << CARD_IDX_W;
    localparam int unsigned CARD_CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } deck_state_e;

endpackage

// File: rtl/card_index_enc.sv
// Packs a card's colour and number into its deck index {color, number}.
// Purely combinational so any card consumer can reuse it.
module card_index_enc
    import card_pkg::*;
#(
    parameter int unsigned COL_W = CARD_COL_W,
    parameter int unsigned NUM_W = CARD_NUM_W
) (
    input  logic [COL_W-1:0]       i_color,
    input  logic [NUM_W-1:0]       i_number,
    output logic [COL_W+NUM_W-1:0] o_idx_c
);

    assign o_idx_c = {i_color, i_number};

endmodule

// File: rtl/card_deck.sv
// Tracks which cards of the deck have been dealt and answers register
// requests with a fixed-latency ack/dup response.
module card_deck
    import card_pkg::*;
#(
    parameter int unsigned COL_W     = CARD_COL_W,
    parameter int unsigned NUM_W     = CARD_NUM_W,
    parameter int unsigned DECK_SIZE = CARD_DECK_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   req,
    input  logic [COL_W-1:0]       color,
    input  logic [NUM_W-1:0]       number,
    output logic                   ack,
    output logic                   dup,
    output logic [COL_W+NUM_W-1:0] card_idx,
    output logic [CARD_CNT_W-1:0]  dealt_cnt,
    output logic                   deck_empty
);

    localparam int unsigned IDX_W = COL_W + NUM_W;
    localparam int unsigned CNT_W = CARD_CNT_W;

    deck_state_e          r_state;
    logic [DECK_SIZE-1:0] r_bitmap;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_card_idx;
    logic                 r_ack;
    logic                 r_dup;
    logic                 r_empty;

    deck_state_e          w_state_nxt;
    logic [DECK_SIZE-1:0] w_bitmap_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_card_idx_nxt;
    logic                 w_ack_nxt;
    logic                 w_dup_nxt;
    logic                 w_empty_nxt;
    logic [IDX_W-1:0]     w_enc_idx;

    card_index_enc #(
        .COL_W (COL_W),
        .NUM_W (NUM_W)
    ) u_enc (
        .i_color  (color),
        .i_number (number),
        .o_idx_c  (w_enc_idx)
    );

    // Next-state logic; clear overrides everything, including a same-edge req.
    always_comb begin
        w_state_nxt    = r_state;
        w_bitmap_nxt   = r_bitmap;
        w_cnt_nxt      = r_cnt;
        w_card_idx_nxt = r_card_idx;
        w_ack_nxt      = 1'b0;
        w_dup_nxt      = 1'b0;
        w_empty_nxt    = r_empty;

        if (clear) begin
            w_state_nxt  = ST_IDLE;
            w_bitmap_nxt = '0;
            w_cnt_nxt    = '0;
            w_empty_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        w_card_idx_nxt = w_enc_idx;
                        w_state_nxt    = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    w_state_nxt = ST_RESP;
                    w_ack_nxt   = 1'b1;
                    // A full deck has every bit set, so the counter cannot overrun.
                    if (r_bitmap[r_card_idx]) begin
                        w_dup_nxt = 1'b1;
                    end else begin
                        w_bitmap_nxt[r_card_idx] = 1'b1;
                        w_cnt_nxt                = r_cnt + CNT_W'(1);
                        w_empty_nxt              = (w_cnt_nxt == CNT_W'(DECK_SIZE));
                    end
                end
                ST_RESP: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bitmap   <= '0;
            r_cnt      <= '0;
            r_card_idx <= '0;
            r_ack      <= 1'b0;
            r_dup      <= 1'b0;
            r_empty    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bitmap   <= w_bitmap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_card_idx <= w_card_idx_nxt;
            r_ack      <= w_ack_nxt;
            r_dup      <= w_dup_nxt;
            r_empty    <= w_empty_nxt;
        end
    end

    assign ack        = r_ack;
    assign dup        = r_dup;
    assign card_idx   = r_card_idx;
    assign dealt_cnt  = r_cnt;
    assign deck_empty = r_empty;

endmodule

// File: tb/tb_card_deck.sv
// Scoreboard bench for card_deck: stimulus pushes expected responses, a
// negedge monitor pops and checks them whenever ack is presented.
module tb_card_deck;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       req;
    logic [1:0] color;
    logic [2:0] number;
    logic       ack;
    logic       dup;
    logic [4:0] card_idx;
    logic [5:0] dealt_cnt;
    logic       deck_empty;

    typedef struct {
        logic       dup;
        logic [4:0] idx;
        logic [5:0] cnt;
        logic       empty;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    card_deck dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req        (req),
        .color      (color),
        .number     (number),
        .ack        (ack),
        .dup        (dup),
        .card_idx   (card_idx),
        .dealt_cnt  (dealt_cnt),
        .deck_empty (deck_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (ack) begin
                if (q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    check("dup", int'(dup), int'(e.dup));
                    check("card_idx", int'(card_idx), int'(e.idx));
                    check("dealt_cnt", int'(dealt_cnt), int'(e.cnt));
                    check("deck_empty", int'(deck_empty), int'(e.empty));
                end
            end else if (dup) begin
                check("dup_without_ack", 1, 0);
            end
        end
    end

    task automatic push(input int c, input int n, input logic d, input int cnt,
                        input logic empty, input int at_cyc);
        exp_t e;
        e.dup   = d;
        e.idx   = 5'(c * 8 + n);
        e.cnt   = 6'(cnt);
        e.empty = empty;
        e.cyc   = at_cyc;
        q.push_back(e);
    endtask

    // One-cycle request; the response is due two edges after the sampling edge.
    task automatic issue(input int c, input int n, input logic d, input int cnt,
                         input logic empty);
        @(posedge clk); #1;
        req    = 1'b1;
        color  = 2'(c);
        number = 3'(n);
        push(c, n, d, cnt, empty, cyc + 2);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int s;
        rst    = 1'b0;
        clear  = 1'b0;
        req    = 1'b0;
        color  = '0;
        number = '0;
        #23;
        check("rst_ack", int'(ack), 0);
        check("rst_dup", int'(dup), 0);
        check("rst_idx", int'(card_idx), 0);
        check("rst_cnt", int'(dealt_cnt), 0);
        check("rst_empty", int'(deck_empty), 0);
        rst = 1'b1;

        // First card, then the same card again.
        issue(2, 5, 1'b0, 1, 1'b0);
        issue(2, 5, 1'b1, 1, 1'b0);

        // Deal the whole deck, then one more.
        do_clear();
        for (int i = 0; i < 32; i++)
            issue(i / 8, i % 8, 1'b0, i + 1, (i == 31));
        issue(0, 0, 1'b1, 32, 1'b1);
        #2;
        check("full_cnt", int'(dealt_cnt), 32);
        check("full_empty", int'(deck_empty), 1);

        // Clear empties the deck.
        do_clear();
        #2;
        check("clear_cnt", int'(dealt_cnt), 0);
        check("clear_empty", int'(deck_empty), 0);

        // req held for 6 sampling edges: two acks, 3 cycles apart.
        @(posedge clk); #1;
        req    = 1'b1;
        color  = 2'd1;
        number = 3'd3;
        s = cyc;
        push(1, 3, 1'b0, 1, 1'b0, s + 2);
        push(1, 3, 1'b1, 1, 1'b0, s + 5);
        repeat (6) @(posedge clk);
        #1;
        req = 1'b0;
        idle(3);

        // req then clear on the next edge: aborted, nothing dealt.
        do_clear();
        @(posedge clk); #1;
        req    = 1'b1;
        color  = 2'd2;
        number = 3'd2;
        @(posedge clk); #1;
        req   = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        idle(4);
        #1;
        check("abort_cnt", int'(dealt_cnt), 0);

        // clear and req on the same edge: req dropped, FSM stays idle.
        @(posedge clk); #1;
        req   = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        req   = 1'b0;
        clear = 1'b0;
        issue(0, 1, 1'b0, 1, 1'b0);
        idle(2);

        // Async reset while in CHECK.
        @(posedge clk); #1;
        req    = 1'b1;
        color  = 2'd1;
        number = 3'd6;
        @(posedge clk); #1;
        req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_ack", int'(ack), 0);
        check("arst_dup", int'(dup), 0);
        check("arst_idx", int'(card_idx), 0);
        check("arst_cnt", int'(dealt_cnt), 0);
        check("arst_empty", int'(deck_empty), 0);
        @(posedge clk); #3;
        rst = 1'b1;
        idle(4);
        issue(3, 7, 1'b0, 1, 1'b0);
        idle(3);

        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
